// File: rtl/abro_stimulus_driver.sv
// Initiator for an ABRO detector: sends R, then A/B events in the commanded order,
// then checks O within a bounded window. Build option: ABRO_EARLY_O_CHECK_EN aborts on an early O.
module abro_stimulus_driver #(
    parameter int GAP_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_order,
    input  logic [GAP_W-1:0] cmd_gap,
    output logic             r_out,
    output logic             a_out,
    output logic             b_out,
    input  logic             o_in,
    output logic             busy,
    output logic             done_valid,
    output logic             done_ok,
    output logic             done_timeout,
    output logic [2:0]       dbg_state
);

    // cmd handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_valid seen in any other state is dropped.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RPULSE = 3'd1,
        EV1    = 3'd2,
        GAP    = 3'd3,
        EV2    = 3'd4,
        WAITO  = 3'd5,
        REPORT = 3'd6
    } state_e;

    localparam logic [1:0] ORD_AB   = 2'b00;
    localparam logic [1:0] ORD_BA   = 2'b01;
    localparam logic [1:0] ORD_BOTH = 2'b10;
    localparam logic [1:0] ORD_NEG  = 2'b11;

    state_e           state_q, state_d;
    logic [1:0]       ord_q, ord_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             ok_d, tmo_d;

    logic cmd_ready_q, r_q, a_q, b_q, busy_q, dv_q, ok_q, tmo_q;
    logic a_d, b_d;

    always_comb begin
        state_d = state_q;
        ord_d   = ord_q;
        gap_d   = gap_q;
        to_d    = to_q;
        ok_d    = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ord_d   = cmd_order;
                    gap_d   = cmd_gap;
                    state_d = RPULSE;
                end
            end
            RPULSE: begin
                state_d = EV1;
`ifdef ABRO_EARLY_O_CHECK_EN
                if (o_in) state_d = REPORT;
`endif
            end
            EV1: begin
                if (ord_q[1]) begin
                    state_d = WAITO;
                    to_d    = TO_W'(TIMEOUT);
                end else if (gap_q == '0) begin
                    state_d = EV2;
                end else begin
                    state_d = GAP;
                end
`ifdef ABRO_EARLY_O_CHECK_EN
                if (!ord_q[1] && o_in) state_d = REPORT;
`endif
            end
            GAP: begin
                // Down-counter stops at 1, so a full-scale gap never wraps.
                if (gap_q == GAP_W'(1)) state_d = EV2;
                else gap_d = gap_q - GAP_W'(1);
`ifdef ABRO_EARLY_O_CHECK_EN
                if (o_in) state_d = REPORT;
`endif
            end
            EV2: begin
                state_d = WAITO;
                to_d    = TO_W'(TIMEOUT);
            end
            WAITO: begin
                if (o_in) begin
                    state_d = REPORT;
                    ok_d    = (ord_q != ORD_NEG);
                end else if (to_q == TO_W'(1)) begin
                    state_d = REPORT;
                    ok_d    = (ord_q == ORD_NEG);
                    tmo_d   = (ord_q != ORD_NEG);
                end else begin
                    to_d = to_q - TO_W'(1);
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each pulse lines up with its state.
    always_comb begin
        a_d = ((state_d == EV1) && (ord_q != ORD_BA)) ||
              ((state_d == EV2) && (ord_q == ORD_BA));
        b_d = ((state_d == EV1) && ((ord_q == ORD_BA) || (ord_q == ORD_BOTH))) ||
              ((state_d == EV2) && (ord_q == ORD_AB));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ord_q       <= 2'b00;
            gap_q       <= '0;
            to_q        <= '0;
            cmd_ready_q <= 1'b1;
            r_q         <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            dv_q        <= 1'b0;
            ok_q        <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ord_q       <= ord_d;
            gap_q       <= gap_d;
            to_q        <= to_d;
            cmd_ready_q <= (state_d == IDLE);
            r_q         <= (state_d == RPULSE);
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= (state_d != IDLE);
            dv_q        <= (state_d == REPORT);
            ok_q        <= ok_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign r_out        = r_q;
    assign a_out        = a_q;
    assign b_out        = b_q;
    assign busy         = busy_q;
    assign done_valid   = dv_q;
    assign done_ok      = ok_q;
    assign done_timeout = tmo_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_abro_stimulus_driver.sv
// Directed bench for abro_stimulus_driver: per-transaction event timing, results and reset.
module tb_abro_stimulus_driver;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_order;
    logic [7:0] cmd_gap;
    logic       r_out, a_out, b_out;
    logic       o_in;
    logic       busy, done_valid, done_ok, done_timeout;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    localparam int MAX_CYC = 400;

    abro_stimulus_driver #(.GAP_W(8), .TIMEOUT(16), .TO_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_order    (cmd_order),
        .cmd_gap      (cmd_gap),
        .r_out        (r_out),
        .a_out        (a_out),
        .b_out        (b_out),
        .o_in         (o_in),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_ok      (done_ok),
        .done_timeout (done_timeout),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({cmd_ready, r_out, a_out, b_out, busy, done_valid, done_ok, done_timeout});
    endfunction

    // Cycle k = k-th cycle after the accepting edge. o_in is raised from cycle o_at (0 = never).
    // Expected first-cycle indices use -1 for "never seen".
    task automatic run_txn(input string tag, input logic [1:0] order, input logic [7:0] gap,
                           input int o_at, input int e_r, input int e_a, input int e_b,
                           input int e_done, input int e_ok, input int e_tmo);
        int k, f_r, f_a, f_b, f_d, n_r, n_a, n_b, bad_ovl, bad_busy, bad_rdy, ok, tmo;
        f_r = -1; f_a = -1; f_b = -1; f_d = -1;
        n_r = 0; n_a = 0; n_b = 0; bad_ovl = 0; bad_busy = 0; bad_rdy = 0; ok = 0; tmo = 0;
        @(negedge clk);
        cmd_order = order;
        cmd_gap   = gap;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // keep cmd_valid up with a different command: it must be ignored while busy
        cmd_order = 2'b11;
        cmd_gap   = 8'd1;
        k = 1;
        while (f_d < 0 && k <= MAX_CYC) begin
            o_in = (o_at > 0 && k >= o_at);
            if (r_out) begin n_r++; if (f_r < 0) f_r = k; end
            if (a_out) begin n_a++; if (f_a < 0) f_a = k; end
            if (b_out) begin n_b++; if (f_b < 0) f_b = k; end
            if (r_out && (a_out || b_out)) bad_ovl++;
            if (!busy) bad_busy++;
            if (cmd_ready) bad_rdy++;
            if (done_valid) begin
                f_d = k;
                ok  = int'(done_ok);
                tmo = int'(done_timeout);
                cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        cmd_valid = 1'b0;
        o_in      = 1'b0;
        chk({tag, "_r_at"}, f_r, e_r);
        chk({tag, "_a_at"}, f_a, e_a);
        chk({tag, "_b_at"}, f_b, e_b);
        chk({tag, "_done_at"}, f_d, e_done);
        chk({tag, "_ok"}, ok, e_ok);
        chk({tag, "_timeout"}, tmo, e_tmo);
        chk({tag, "_r_cnt"}, n_r, 1);
        chk({tag, "_a_cnt"}, n_a, (e_a >= 0) ? 1 : 0);
        chk({tag, "_b_cnt"}, n_b, (e_b >= 0) ? 1 : 0);
        chk({tag, "_r_overlap"}, bad_ovl, 0);
        chk({tag, "_busy_low"}, bad_busy, 0);
        chk({tag, "_ready_high"}, bad_rdy, 0);
        // cycle after done: back in IDLE
        chk({tag, "_post_idle"}, out_vec(), 8'b1000_0000);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_order = 2'b00;
        cmd_gap   = 8'd0;
        o_in      = 1'b0;
        #12;
        chk("reset_outputs", out_vec(), 8'b1000_0000);
        chk("reset_state", int'(dbg_state), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // A then B, gap 3, O one cycle after B
        run_txn("ab_gap3", 2'b00, 8'd3, 7, 1, 2, 6, 8, 1, 0);
        // B then A, no gap, O one cycle after A
        run_txn("ba_gap0", 2'b01, 8'd0, 4, 1, 3, 2, 5, 1, 0);
        // A and B together, O never: 16 WAITO cycles then timeout
        run_txn("both_to", 2'b10, 8'd9, 0, 1, 2, 2, 19, 0, 1);
        // negative test, O never: pass after the window
        run_txn("neg_quiet", 2'b11, 8'd4, 0, 1, 2, -1, 19, 1, 0);
        // negative test, O two cycles after A: fail without timeout
        run_txn("neg_hit", 2'b11, 8'd0, 4, 1, 2, -1, 5, 0, 0);
        // full-scale gap, O on the last cycle of the window
        run_txn("ab_gap255", 2'b00, 8'd255, 274, 1, 2, 258, 275, 1, 0);

        // O raised in the 2nd GAP cycle and held
`ifdef ABRO_EARLY_O_CHECK_EN
        run_txn("early_o", 2'b00, 8'd5, 4, 1, 2, -1, 5, 0, 0);
`else
        run_txn("early_o", 2'b00, 8'd5, 4, 1, 2, 8, 10, 1, 0);
`endif

        // reset in the middle of a long gap
        @(negedge clk);
        cmd_order = 2'b00;
        cmd_gap   = 8'd200;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (9) @(posedge clk);
        chk("mid_gap_busy", int'(busy), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", out_vec(), 8'b1000_0000);
        chk("rst_async_state", int'(dbg_state), 0);
        begin
            int seen_dv;
            seen_dv = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                if (done_valid) seen_dv++;
            end
            chk("rst_no_done", seen_dv, 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_txn("after_rst", 2'b00, 8'd3, 7, 1, 2, 6, 8, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/abro_stimulus_driver.md
Name: abro_stimulus_driver

Overview:
- Initiator side of the ABRO event interface. It drives the R, A and B event pulses into an ABRO-style detector and watches the detector's O output.
- Accepts one command per transaction on a valid/ready port: event order plus inter-event gap. It then sequences R, first event, gap, second event, and waits a bounded window for O.
- Reports pass, fail or timeout on a one-cycle done strobe.
- Used in the test harness and in self-test logic next to the ABRO detector.

Parameters:
- GAP_W, 8, width of the inter-event gap count.
- TIMEOUT, 16, number of cycles to wait for O after the last event (>=1).
- TO_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command; high only in IDLE.
- cmd_order  in  2  00 = A then B; 01 = B then A; 10 = A and B together; 11 = A only (negative test).
- cmd_gap  in  GAP_W  idle cycles between first and second event.
- r_out  out  1  reset-event pulse to the detector.
- a_out  out  1  A event pulse.
- b_out  out  1  B event pulse.
- o_in  in  1  detector output O.
- busy  out  1  high in any state other than IDLE.
- done_valid  out  1  one-cycle result strobe.
- done_ok  out  1  result is pass; valid only with done_valid.
- done_timeout  out  1  O was expected but never seen; valid only with done_valid.

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1; state = IDLE; counters = 0.
- All outputs are registered.
- States and transitions:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch cmd_order and cmd_gap, then go to RPULSE.
  - RPULSE: r_out = 1 for exactly one cycle, then go to EV1.
  - EV1: drive one cycle of the first event.
    - Order 00 or 11: a_out. Order 01: b_out. Order 10: a_out and b_out together.
    - Next state: order 10 or 11 goes to WAITO. Otherwise go to GAP, or straight to EV2 if the gap is 0.
  - GAP: hold all event outputs low for exactly cmd_gap cycles, then go to EV2.
  - EV2: one cycle of the second event (b_out for order 00, a_out for order 01), then go to WAITO.
  - WAITO: load the timeout counter with TIMEOUT and sample o_in each cycle.
    - Orders 00, 01, 10: the first cycle with o_in = 1 goes to REPORT with ok = 1. If the counter expires, go to REPORT with ok = 0 and timeout = 1.
    - Order 11: any o_in = 1 goes to REPORT with ok = 0 and timeout = 0. If the counter expires, go to REPORT with ok = 1.
  - REPORT: done_valid = 1 for one cycle with done_ok/done_timeout, then go to IDLE.
- Latency from command acceptance to the first edge of r_out is 1 cycle.
- Transaction length, with gap g and O response delay d (1..TIMEOUT):
  - Orders 00/01: 1 + 1 + 1 + g + 1 + d + 1 cycles.
  - Orders 10/11: 1 + 1 + 1 + d + 1 cycles.
- At most one event output is high per cycle, except EV1 with order 10.
- r_out never overlaps a_out or b_out.
- o_in is ignored outside WAITO (subject to the optional feature below).
- cmd_valid outside IDLE is ignored and not queued.
- Reset asserted mid-transaction: return to IDLE immediately and drop all pulses. No done strobe is issued.
- Gap counter: down-counter loaded from cmd_gap; a maximum gap of 2^GAP_W - 1 must not wrap.

Optional Feature:
- Macro ABRO_EARLY_O_CHECK_EN.
- When defined, o_in is also monitored in the states RPULSE, EV1 (orders 00/01 only) and GAP.
- With the macro: o_in = 1 in any of those states aborts the sequence immediately to REPORT with done_ok = 0 and done_timeout = 0. No further event pulses are driven.
- Without the macro: o_in is ignored outside WAITO, as specified above.

Test Plan:
- order=00, gap=3, detector asserts O 1 cycle after B: r_out at t+1, a_out at t+2, b_out at t+6, done_valid at t+8 with ok=1, timeout=0.
- order=01, gap=0: b_out at t+2, a_out at t+3; O 1 cycle later, so done ok=1. Check that cmd_ready stays low until the cycle after done_valid.
- order=10, O held low, TIMEOUT=16: a_out and b_out together at t+2, done_valid after 16 WAITO cycles with ok=0, timeout=1.
- order=11, O stays low: done ok=1 after TIMEOUT. Repeat with O forced high 2 cycles after A: done ok=0, timeout=0.
- reset_n pulsed low during GAP (gap=200): all outputs return to reset values asynchronously, no done_valid, and the next command runs normally.
- With ABRO_EARLY_O_CHECK_EN defined, order=00, gap=5, O forced high in the 2nd GAP cycle: no b_out, done ok=0, timeout=0.
